// File: rtl/itch_arb_pkg.sv
// Shared constants and the round-robin search used by the ITCH decoder arbiter.
package itch_arb_pkg;

  localparam int CH_ADD     = 0;
  localparam int CH_CANCEL  = 1;
  localparam int CH_DELETE  = 2;
  localparam int CH_REPLACE = 3;
  localparam int CH_EXEC    = 4;

  localparam int DROP_CNT_W = 16;

  // Upper bound on channel count handled by rr_next; masks are zero-padded to this width.
  localparam int MAX_CH   = 32;
  localparam int MAX_CH_W = 5;

  // First set bit of mask searching last+1, last+2, ... modulo num_ch; returns last if mask is empty.
  function automatic int rr_next(input logic [MAX_CH-1:0] mask, input int num_ch, input int last);
    int  idx;
    int  win;
    bit  found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      if (i <= num_ch && !found) begin
        idx = last + i;
        if (idx >= num_ch) idx = idx - num_ch;
        if (mask[idx[MAX_CH_W-1:0]]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/itch_sync_fifo.sv
// Single-clock FIFO with combinational read port; pop on empty and push on full are ignored,
// except that a push on full is taken when a pop happens on the same edge.
module itch_sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/itch_decoder_arbiter.sv
// Merges per-channel ITCH decoder pulses through per-channel FIFOs into one round-robin ready/valid stream.
// Define ITCH_ARB_DROP_CNT_EN to add the per-channel saturating drop_cnt port and counters.
module itch_decoder_arbiter
  import itch_arb_pkg::*;
#(
  parameter int NUM_CH     = 5,
  parameter int PAYLOAD_W  = 256,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             dec_valid,
  input  logic [NUM_CH-1:0]             dec_invalid,
  input  logic [NUM_CH*PAYLOAD_W-1:0]   dec_payload,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_W-1:0]               out_ch,
  output logic [PAYLOAD_W-1:0]          out_payload,
  output logic [NUM_CH-1:0]             overflow
`ifdef ITCH_ARB_DROP_CNT_EN
  ,output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic [NUM_CH-1:0]    push_req;
  logic [NUM_CH-1:0]    fifo_empty;
  logic [NUM_CH-1:0]    fifo_full;
  logic [NUM_CH-1:0]    fifo_pop;
  logic [NUM_CH-1:0]    drop_evt;
  logic [PAYLOAD_W-1:0] fifo_dout [NUM_CH];
  logic [CH_W-1:0]      last_grant;
  logic [CH_W-1:0]      winner;
  logic                 any_pending;
  logic                 load;

  assign push_req    = dec_valid & ~dec_invalid;
  assign any_pending = |(~fifo_empty);
  assign load        = !out_valid || out_ready;
  // A full FIFO still accepts when it is being popped on the same edge.
  assign drop_evt    = push_req & fifo_full & ~fifo_pop;

  always_comb begin
    winner   = CH_W'(rr_next(MAX_CH'(~fifo_empty), NUM_CH, int'(last_grant)));
    fifo_pop = '0;
    if (load && any_pending) fifo_pop[winner] = 1'b1;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    itch_sync_fifo #(
      .WIDTH (PAYLOAD_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req[gi]),
      .pop   (fifo_pop[gi]),
      .din   (dec_payload[gi*PAYLOAD_W +: PAYLOAD_W]),
      .dout  (fifo_dout[gi]),
      .empty (fifo_empty[gi]),
      .full  (fifo_full[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_payload <= '0;
      last_grant  <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      if (any_pending) begin
        out_valid   <= 1'b1;
        out_ch      <= winner;
        out_payload <= fifo_dout[winner];
        last_grant  <= winner;
      end else begin
        out_valid   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) overflow <= '0;
    else     overflow <= overflow | drop_evt;
  end

`ifdef ITCH_ARB_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (drop_evt[i] && drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] != '1)
          drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] <= drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_itch_decoder_arbiter.sv
// Bench for itch_decoder_arbiter: queue-based reference model checked every cycle, plus directed literals.
module tb_itch_decoder_arbiter;

  localparam int NCH = 5;
  localparam int PW  = 256;
  localparam int DEP = 4;

  typedef logic [PW-1:0] pl_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCH-1:0]  dec_valid = '0;
  logic [NCH-1:0]  dec_invalid = '0;
  logic [NCH*PW-1:0] dec_payload = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2:0]      out_ch;
  pl_t             out_payload;
  logic [NCH-1:0]  overflow;
`ifdef ITCH_ARB_DROP_CNT_EN
  logic [NCH*16-1:0] drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  itch_decoder_arbiter #(.NUM_CH(NCH), .PAYLOAD_W(PW), .FIFO_DEPTH(DEP)) dut (
    .clk         (clk),
    .rst         (rst),
    .dec_valid   (dec_valid),
    .dec_invalid (dec_invalid),
    .dec_payload (dec_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_payload (out_payload),
`ifdef ITCH_ARB_DROP_CNT_EN
    .drop_cnt    (drop_cnt),
`endif
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input pl_t act, input pl_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel queues, a single output slot, and a round-robin pointer.
  pl_t      mq [NCH][$];
  bit       m_v    = 1'b0;
  int       m_ch   = 0;
  pl_t      m_pl   = '0;
  int       m_last = NCH - 1;
  bit [NCH-1:0] m_ov = '0;
  int       m_dc [NCH];

  initial begin
    bit              r;
    bit              rdy;
    logic [NCH-1:0]  dv;
    logic [NCH-1:0]  di;
    logic [NCH*PW-1:0] dp;
    bit              found;
    for (int i = 0; i < NCH; i++) m_dc[i] = 0;
    forever begin
      @(posedge clk);
      r = rst; rdy = out_ready; dv = dec_valid; di = dec_invalid; dp = dec_payload;
      if (r) begin
        for (int i = 0; i < NCH; i++) begin
          mq[i].delete();
          m_dc[i] = 0;
        end
        m_v = 0; m_ch = 0; m_pl = '0; m_last = NCH - 1; m_ov = '0;
      end else begin
        if (!m_v || rdy) begin
          found = 0;
          for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_last + k) % NCH;
            if (!found && mq[c].size() > 0) begin
              found  = 1;
              m_ch   = c;
              m_pl   = mq[c].pop_front();
              m_last = c;
            end
          end
          m_v = found;
        end
        for (int i = 0; i < NCH; i++) begin
          if (dv[i] && !di[i]) begin
            if (mq[i].size() < DEP) mq[i].push_back(dp[i*PW +: PW]);
            else begin
              m_ov[i] = 1'b1;
              if (m_dc[i] < 65535) m_dc[i]++;
            end
          end
        end
      end
      @(negedge clk);
      check("model out_valid", pl_t'(out_valid), pl_t'(m_v));
      check("model out_ch", pl_t'(out_ch), pl_t'(m_ch));
      check("model out_payload", out_payload, m_pl);
      check("model overflow", pl_t'(overflow), pl_t'(m_ov));
`ifdef ITCH_ARB_DROP_CNT_EN
      for (int i = 0; i < NCH; i++)
        check("model drop_cnt", pl_t'(drop_cnt[i*16 +: 16]), pl_t'(m_dc[i][15:0]));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    dec_valid   = '0;
    dec_invalid = '0;
    rst         = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic push(input int ch, input pl_t v);
    dec_valid[ch] = 1'b1;
    dec_payload[ch*PW +: PW] = v;
  endtask

  initial begin
    int  acc_ch [$];
    pl_t acc_pl [$];
    int  exp_ch [6];
    pl_t exp_pl [6];
    exp_ch = '{0, 4, 0, 4, 0, 4};
    exp_pl = '{pl_t'('h500), pl_t'('h540), pl_t'('h501), pl_t'('h541), pl_t'('h502), pl_t'('h542)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", pl_t'(out_valid), '0);
    check("reset out_ch", pl_t'(out_ch), '0);
    check("reset out_payload", out_payload, '0);
    check("reset overflow", pl_t'(overflow), '0);

    // 1: single push on channel 2, two-cycle latency
    do_reset();
    out_ready = 1'b1;
    cyc();
    push(2, 'hDEAD);
    cyc();
    @(negedge clk);
    check("t1 no bypass", pl_t'(out_valid), '0);
    cyc();
    @(negedge clk);
    check("t1 out_valid", pl_t'(out_valid), 1);
    check("t1 out_ch", pl_t'(out_ch), 2);
    check("t1 out_payload", out_payload, 'hDEAD);
    cyc();
    @(negedge clk);
    check("t1 drained", pl_t'(out_valid), '0);
    check("t1 payload hold", out_payload, 'hDEAD);

    // 2: all channels at once, drained 0..4
    do_reset();
    out_ready = 1'b1;
    cyc();
    for (int i = 0; i < NCH; i++) push(i, pl_t'(i));
    cyc();
    cyc();
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      check("t2 out_valid", pl_t'(out_valid), 1);
      check("t2 out_ch", pl_t'(out_ch), pl_t'(k));
      check("t2 out_payload", out_payload, pl_t'(k));
      cyc();
    end
    @(negedge clk);
    check("t2 idle", pl_t'(out_valid), '0);

    // 3: stalled output, six pushes into a depth-4 FIFO drop one
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      push(1, pl_t'('h100 + k));
    end
    cyc();
    @(negedge clk);
    check("t3 out_valid", pl_t'(out_valid), 1);
    check("t3 out holds first", out_payload, 'h100);
    check("t3 overflow", pl_t'(overflow), pl_t'(5'b00010));
`ifdef ITCH_ARB_DROP_CNT_EN
    check("t3 drop_cnt1", pl_t'(drop_cnt[16 +: 16]), 1);
`endif
    cyc();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3 drain payload", out_payload, pl_t'('h100 + k));
      cyc();
    end
    @(negedge clk);
    check("t3 empty after drain", pl_t'(out_valid), '0);
    check("t3 overflow sticky", pl_t'(overflow[1]), 1);

    // 4: invalid packet is discarded silently
    do_reset();
    out_ready = 1'b1;
    cyc();
    dec_valid[3] = 1'b1;
    dec_invalid[3] = 1'b1;
    dec_payload[3*PW +: PW] = 'h333;
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      check("t4 no out_valid", pl_t'(out_valid), '0);
      check("t4 no overflow", pl_t'(overflow), '0);
    end

    // 5: back-pressure with channels 0 and 4 busy
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc();
      out_ready = (c % 2 == 0);
      if (c < 3) begin
        push(0, pl_t'('h500 + c));
        push(4, pl_t'('h540 + c));
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        acc_ch.push_back(int'(out_ch));
        acc_pl.push_back(out_payload);
      end
    end
    check("t5 accepted count", pl_t'(acc_ch.size()), 6);
    for (int k = 0; k < 6 && k < acc_ch.size(); k++) begin
      check("t5 rr channel", pl_t'(acc_ch[k]), pl_t'(exp_ch[k]));
      check("t5 rr payload", acc_pl[k], exp_pl[k]);
    end

    // 6: reset with records queued and an overflow flagged
    do_reset();
    out_ready = 1'b0;
    cyc();
    push(0, 'h600); push(1, 'h610); push(2, 'h620);
    for (int k = 1; k < 6; k++) begin
      cyc();
      push(0, pl_t'('h600 + k));
    end
    cyc();
    @(negedge clk);
    check("t6 overflow before rst", pl_t'(overflow[0]), 1);
    cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    check("t6 out_valid after rst", pl_t'(out_valid), '0);
    check("t6 overflow after rst", pl_t'(overflow), '0);
    out_ready = 1'b1;
    push(0, 'h77);
    cyc();
    @(negedge clk);
    check("t6 no stale record", pl_t'(out_valid), '0);
    cyc();
    @(negedge clk);
    check("t6 post-rst valid", pl_t'(out_valid), 1);
    check("t6 post-rst ch", pl_t'(out_ch), '0);
    check("t6 post-rst payload", out_payload, 'h77);
    cyc();
    @(negedge clk);
    check("t6 only one record", pl_t'(out_valid), '0);

    repeat (2) cyc();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
